// File: rtl/riscv_pma_checker.sv
// rtl/riscv_pma_checker.sv - programmable PMA region table with registered attribute/fault lookup
package riscv_pma_pkg;
  localparam logic [1:0] A_OFF   = 2'd0;
  localparam logic [1:0] A_TOR   = 2'd1;
  localparam logic [1:0] A_NA4   = 2'd2;
  localparam logic [1:0] A_NAPOT = 2'd3;

  localparam logic [1:0] MT_EMPTY = 2'd0;
  localparam logic [1:0] MT_MAIN  = 2'd1;
  localparam logic [1:0] MT_IO    = 2'd2;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] mem_type;
    logic       r;
    logic       w;
    logic       x;
    logic       c;
    logic       m;
  } pmacfg_t;
endpackage

module riscv_pma_checker
  import riscv_pma_pkg::*;
#(
  parameter int PLEN    = 32,
  parameter int PMA_CNT = 4,
  localparam int IW     = (PMA_CNT > 1) ? $clog2(PMA_CNT) : 1
) (
  input  logic            rst_ni,
  input  logic            clk_i,
  input  logic            cfg_we_i,
  input  logic [IW-1:0]   cfg_idx_i,
  input  pmacfg_t         cfg_i,
  input  logic [PLEN-3:0] cfg_adr_i,
  input  logic            req_i,
  input  logic [PLEN-1:0] adr_i,
  input  logic [1:0]      size_i,
  input  logic            instr_i,
  input  logic            we_i,
  input  logic            stall_i,
  output logic            pma_valid_o,
  output pmacfg_t         pma_o,
  output logic            exception_o,
  output logic            misaligned_o,
  output logic            cacheable_o
);

  localparam int AW = PLEN - 2;

  pmacfg_t          cfg_q  [PMA_CNT];
  logic [AW-1:0]    addr_q [PMA_CNT];
  logic [AW-1:0]    wadr;
  logic [PMA_CNT-1:0] match;

  assign wadr = adr_i[PLEN-1:2];

  // Bits covered by the run of trailing ones (and everything below) are don't-care.
  function automatic logic [AW-1:0] napot_care(input logic [AW-1:0] a);
    logic          run;
    logic [AW-1:0] care;
    run  = 1'b1;
    care = '0;
    for (int j = 0; j < AW; j++) begin
      run     = run & a[j];
      care[j] = ~run;
    end
    return care;
  endfunction

  for (genvar i = 0; i < PMA_CNT; i++) begin : g_match
    logic [AW-1:0] lo;
    logic [AW-1:0] care;
    if (i == 0) begin : g_lo0
      assign lo = '0;
    end else begin : g_lo
      assign lo = addr_q[i-1];
    end
    assign care     = napot_care(addr_q[i]);
    assign match[i] = (cfg_q[i].a == A_TOR)   ? ((wadr >= lo) && (wadr < addr_q[i])) :
                      (cfg_q[i].a == A_NA4)   ? (wadr == addr_q[i]) :
                      (cfg_q[i].a == A_NAPOT) ? (((wadr ^ addr_q[i]) & care) == '0) :
                                                1'b0;
  end

  pmacfg_t sel;
  logic    hit;
  logic    perm;
  logic    mis_addr;
  logic    res_exc;
  logic    res_mis;
  logic    res_cach;

  always_comb begin
    sel = '0;
    hit = 1'b0;
    // Descending scan so the lowest matching index is the last to win.
    for (int i = PMA_CNT - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit = 1'b1;
        sel = cfg_q[i];
      end
    end
    case (size_i)
      2'd0:    mis_addr = 1'b0;
      2'd1:    mis_addr = adr_i[0];
      2'd2:    mis_addr = |adr_i[1:0];
      default: mis_addr = |adr_i[2:0];
    endcase
    perm     = instr_i ? sel.x : (we_i ? sel.w : sel.r);
    res_mis  = hit & mis_addr & ~sel.m;
    res_exc  = ~hit | ~perm | res_mis;
    res_cach = hit & (sel.mem_type == MT_MAIN) & sel.c;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < PMA_CNT; i++) begin
        cfg_q[i]  <= '0;
        addr_q[i] <= '0;
      end
      pma_valid_o  <= 1'b0;
      pma_o        <= '0;
      exception_o  <= 1'b0;
      misaligned_o <= 1'b0;
      cacheable_o  <= 1'b0;
    end else begin
      if (cfg_we_i && (int'(cfg_idx_i) < PMA_CNT)) begin
        cfg_q[cfg_idx_i]  <= cfg_i;
        addr_q[cfg_idx_i] <= cfg_adr_i;
      end
      if (!stall_i) begin
        pma_valid_o  <= req_i;
        pma_o        <= sel;
        exception_o  <= res_exc;
        misaligned_o <= res_mis;
        cacheable_o  <= res_cach;
      end
    end
  end

endmodule
